// File: rtl/axis_hex_formatter_if.sv
// AXI-Stream bundle shared by the hex formatter and its neighbours.
// The clock is carried along so both ends of a stream see the same edge.
interface axis_interface #(
   parameter int DATA_WIDTH = 8
) (
   input logic clk
);
   localparam int KEEP_WIDTH = (DATA_WIDTH + 7) / 8;

   logic [DATA_WIDTH-1:0] tdata;
   logic                  tvalid;
   logic                  tready;
   logic                  tlast;
   logic [KEEP_WIDTH-1:0] tkeep;
   logic                  tuser;
   logic [3:0]            tid;
   logic [3:0]            tdest;

   modport Source (
      input  clk, tready,
      output tdata, tvalid, tlast, tkeep, tuser, tid, tdest
   );

   modport Sink (
      input  clk, tdata, tvalid, tlast, tkeep, tuser, tid, tdest,
      output tready
   );
endinterface

// File: rtl/axis_hex_formatter.sv
// Turns binary sample words into ASCII hex text, MSB nibble first, with a
// separator between words and CR LF (tlast on LF) closing each frame.
module axis_hex_formatter #(
   parameter int         INPUT_WIDTH = 16,
   parameter bit         UPPERCASE   = 1'b1,
   parameter logic [7:0] SEPARATOR   = 8'h2C
) (
   input logic          clk,
   input logic          reset,
   axis_interface.Sink   sample_stream,
   axis_interface.Source char_stream
);
   localparam int DIGITS = INPUT_WIDTH / 4;
   localparam logic [2:0] TOP_IDX = 3'(DIGITS - 1);

   typedef enum logic [2:0] {IDLE, DIGIT, SEP, CR, LF} state_t;

   state_t                 state, state_next;
   logic [INPUT_WIDTH-1:0] word_q, word_next;
   logic                   last_q, last_next;
   logic [2:0]             digit_idx, idx_next;
   logic [7:0]             data_q, data_next;
   logic                   valid_q, valid_next;
   logic                   tlast_q, tlast_next;
   logic                   take;
   logic                   unused_sideband;

   function automatic logic [7:0] hex_char(input logic [3:0] nib);
      if (nib < 4'd10)
         return 8'h30 + {4'h0, nib};
      else
         return (UPPERCASE ? 8'h41 : 8'h61) + {4'h0, nib - 4'd10};
   endfunction

   function automatic logic [3:0] nibble_at(input logic [INPUT_WIDTH-1:0] w,
                                            input logic [2:0] idx);
      return 4'(w >> (4 * idx));
   endfunction

   assign sample_stream.tready = (state == IDLE) && reset;
   assign take                 = sample_stream.tvalid && sample_stream.tready;

   assign char_stream.tdata  = data_q;
   assign char_stream.tvalid = valid_q;
   assign char_stream.tlast  = tlast_q;
   assign char_stream.tkeep  = '1;
   assign char_stream.tuser  = 1'b0;
   assign char_stream.tid    = '0;
   assign char_stream.tdest  = '0;

   // Sideband fields carry nothing this block cares about.
   assign unused_sideband = ^{sample_stream.tkeep, sample_stream.tuser, sample_stream.tid,
                              sample_stream.tdest, sample_stream.clk, char_stream.clk};

   // All outputs are registered; reset abandons any partially printed line.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         word_q    <= '0;
         last_q    <= 1'b0;
         digit_idx <= '0;
         data_q    <= 8'h00;
         valid_q   <= 1'b0;
         tlast_q   <= 1'b0;
      end else begin
         state     <= state_next;
         word_q    <= word_next;
         last_q    <= last_next;
         digit_idx <= idx_next;
         data_q    <= data_next;
         valid_q   <= valid_next;
         tlast_q   <= tlast_next;
      end
   end

   // Every non-IDLE state has tvalid high, so tready alone marks a handshake
   // and the output holds still until the sink takes it.
   always_comb begin
      state_next = state;
      word_next  = word_q;
      last_next  = last_q;
      idx_next   = digit_idx;
      data_next  = data_q;
      valid_next = valid_q;
      tlast_next = tlast_q;
      unique case (state)
         IDLE: begin
            if (take) begin
               word_next  = sample_stream.tdata;
               last_next  = sample_stream.tlast;
               idx_next   = TOP_IDX;
               data_next  = hex_char(nibble_at(sample_stream.tdata, TOP_IDX));
               valid_next = 1'b1;
               state_next = DIGIT;
            end
         end
         DIGIT: begin
            if (char_stream.tready) begin
               if (digit_idx != 3'd0) begin
                  idx_next  = digit_idx - 3'd1;
                  data_next = hex_char(nibble_at(word_q, digit_idx - 3'd1));
               end else if (last_q) begin
                  data_next  = 8'h0D;
                  state_next = CR;
               end else begin
                  data_next  = SEPARATOR;
                  state_next = SEP;
               end
            end
         end
         SEP: begin
            if (char_stream.tready) begin
               valid_next = 1'b0;
               state_next = IDLE;
            end
         end
         CR: begin
            if (char_stream.tready) begin
               data_next  = 8'h0A;
               tlast_next = 1'b1;
               state_next = LF;
            end
         end
         LF: begin
            if (char_stream.tready) begin
               valid_next = 1'b0;
               tlast_next = 1'b0;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end
endmodule

// File: tb/tb_axis_hex_formatter.sv
// Scoreboard bench for axis_hex_formatter: default, lowercase and 8-bit
// instances share one clock and reset.
module tb_axis_hex_formatter;
   logic clk;
   logic reset;
   int   cyc;
   int   checks;
   int   errors;

   axis_interface #(.DATA_WIDTH(16)) in_a  (clk);
   axis_interface #(.DATA_WIDTH(8))  out_a (clk);
   axis_interface #(.DATA_WIDTH(16)) in_b  (clk);
   axis_interface #(.DATA_WIDTH(8))  out_b (clk);
   axis_interface #(.DATA_WIDTH(8))  in_c  (clk);
   axis_interface #(.DATA_WIDTH(8))  out_c (clk);

   axis_hex_formatter u_dut_a (.clk(clk), .reset(reset), .sample_stream(in_a), .char_stream(out_a));
   axis_hex_formatter #(.UPPERCASE(1'b0)) u_dut_b (.clk(clk), .reset(reset),
                                                   .sample_stream(in_b), .char_stream(out_b));
   axis_hex_formatter #(.INPUT_WIDTH(8)) u_dut_c (.clk(clk), .reset(reset),
                                                  .sample_stream(in_c), .char_stream(out_c));

   logic [8:0] exp_a[$];
   logic [8:0] exp_b[$];
   logic [8:0] exp_c[$];
   int beats_a, beats_b, beats_c;
   int lasts_a, lasts_b, lasts_c;
   logic [8:0] e_a, e_b, e_c;
   logic [9:0] snap_a, snap_b, snap_c;
   bit hold_a, hold_b, hold_c;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: run still going, required a finish");
      $fatal(1, "[TB] watchdog");
   end

   // Output monitors: pop the scoreboard on every handshake and insist a
   // stalled beat stays frozen until it is taken.
   always @(negedge clk) begin
      if (reset) begin
         if (out_a.tvalid && out_a.tready) begin
            checks++;
            if (exp_a.size() == 0) begin
               errors++;
               $display("[TB] FAIL mon_a_extra: got %h last %b, required no byte", out_a.tdata, out_a.tlast);
            end else begin
               e_a = exp_a.pop_front();
               if ({out_a.tlast, out_a.tdata} !== e_a) begin
                  errors++;
                  $display("[TB] FAIL mon_a_byte: got %h, required %h", {out_a.tlast, out_a.tdata}, e_a);
               end
            end
            beats_a++;
            if (out_a.tlast) lasts_a++;
         end
         if (hold_a) begin
            checks++;
            if ({out_a.tvalid, out_a.tlast, out_a.tdata} !== snap_a) begin
               errors++;
               $display("[TB] FAIL mon_a_stable: got %h, required %h", {out_a.tvalid, out_a.tlast, out_a.tdata}, snap_a);
            end
         end
         hold_a = out_a.tvalid && !out_a.tready;
         snap_a = {out_a.tvalid, out_a.tlast, out_a.tdata};
      end else hold_a = 1'b0;
   end

   always @(negedge clk) begin
      if (reset) begin
         if (out_b.tvalid && out_b.tready) begin
            checks++;
            if (exp_b.size() == 0) begin
               errors++;
               $display("[TB] FAIL mon_b_extra: got %h, required no byte", out_b.tdata);
            end else begin
               e_b = exp_b.pop_front();
               if ({out_b.tlast, out_b.tdata} !== e_b) begin
                  errors++;
                  $display("[TB] FAIL mon_b_byte: got %h, required %h", {out_b.tlast, out_b.tdata}, e_b);
               end
            end
            beats_b++;
            if (out_b.tlast) lasts_b++;
         end
         if (hold_b) begin
            checks++;
            if ({out_b.tvalid, out_b.tlast, out_b.tdata} !== snap_b) begin
               errors++;
               $display("[TB] FAIL mon_b_stable: got %h, required %h", {out_b.tvalid, out_b.tlast, out_b.tdata}, snap_b);
            end
         end
         hold_b = out_b.tvalid && !out_b.tready;
         snap_b = {out_b.tvalid, out_b.tlast, out_b.tdata};
      end else hold_b = 1'b0;
   end

   always @(negedge clk) begin
      if (reset) begin
         if (out_c.tvalid && out_c.tready) begin
            checks++;
            if (exp_c.size() == 0) begin
               errors++;
               $display("[TB] FAIL mon_c_extra: got %h, required no byte", out_c.tdata);
            end else begin
               e_c = exp_c.pop_front();
               if ({out_c.tlast, out_c.tdata} !== e_c) begin
                  errors++;
                  $display("[TB] FAIL mon_c_byte: got %h, required %h", {out_c.tlast, out_c.tdata}, e_c);
               end
            end
            beats_c++;
            if (out_c.tlast) lasts_c++;
         end
         if (hold_c) begin
            checks++;
            if ({out_c.tvalid, out_c.tlast, out_c.tdata} !== snap_c) begin
               errors++;
               $display("[TB] FAIL mon_c_stable: got %h, required %h", {out_c.tvalid, out_c.tlast, out_c.tdata}, snap_c);
            end
         end
         hold_c = out_c.tvalid && !out_c.tready;
         snap_c = {out_c.tvalid, out_c.tlast, out_c.tdata};
      end else hold_c = 1'b0;
   end

   function automatic logic in_ready(input int which);
      case (which)
         0:       return in_a.tready;
         1:       return in_b.tready;
         default: return in_c.tready;
      endcase
   endfunction

   function automatic int exp_size(input int which);
      case (which)
         0:       return exp_a.size();
         1:       return exp_b.size();
         default: return exp_c.size();
      endcase
   endfunction

   task automatic push_exp(input int which, input logic [8:0] v);
      case (which)
         0:       exp_a.push_back(v);
         1:       exp_b.push_back(v);
         default: exp_c.push_back(v);
      endcase
   endtask

   // Reference model of the text a word should turn into.
   task automatic expect_word(input int which, input logic [31:0] w, input int digits,
                              input bit last, input bit upper);
      logic [3:0] nib;
      logic [7:0] ch;
      for (int i = digits - 1; i >= 0; i--) begin
         nib = w[4*i +: 4];
         if (nib < 4'd10) ch = 8'h30 + 8'(nib);
         else             ch = (upper ? 8'h41 : 8'h61) + 8'(nib) - 8'd10;
         push_exp(which, {1'b0, ch});
      end
      if (last) begin
         push_exp(which, {1'b0, 8'h0D});
         push_exp(which, {1'b1, 8'h0A});
      end else begin
         push_exp(which, {1'b0, 8'h2C});
      end
   endtask

   task automatic send(input int which, input logic [31:0] w, input bit last, output int acc);
      bit done;
      done = 1'b0;
      acc  = -1;
      @(posedge clk); #1;
      case (which)
         0:       begin in_a.tdata = w[15:0]; in_a.tlast = last; in_a.tvalid = 1'b1; end
         1:       begin in_b.tdata = w[15:0]; in_b.tlast = last; in_b.tvalid = 1'b1; end
         default: begin in_c.tdata = w[7:0];  in_c.tlast = last; in_c.tvalid = 1'b1; end
      endcase
      expect_word(which, w, (which == 2) ? 2 : 4, last, which != 1);
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (in_ready(which)) begin
            acc  = cyc;
            done = 1'b1;
         end
      end
      @(posedge clk); #1;
      case (which)
         0:       in_a.tvalid = 1'b0;
         1:       in_b.tvalid = 1'b0;
         default: in_c.tvalid = 1'b0;
      endcase
      if (!done) begin
         checks++;
         errors++;
         $display("[TB] FAIL send_timeout: dut %0d word %h not accepted, required accept", which, w);
      end
   endtask

   task automatic wait_drain(input int which);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 400 && !done; i++) begin
         @(posedge clk);
         if (exp_size(which) == 0) done = 1'b1;
      end
      #1;
      checks++;
      if (!done) begin
         errors++;
         $display("[TB] FAIL drain_timeout: dut %0d still owes %0d bytes, required 0", which, exp_size(which));
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      #12;
      checks += 5;
      if (out_a.tvalid !== 1'b0) begin errors++; $display("[TB] FAIL rst_tvalid: got %b, required 0", out_a.tvalid); end
      if (out_a.tdata !== 8'h00) begin errors++; $display("[TB] FAIL rst_tdata: got %h, required 00", out_a.tdata); end
      if (out_a.tlast !== 1'b0)  begin errors++; $display("[TB] FAIL rst_tlast: got %b, required 0", out_a.tlast); end
      if (in_a.tready !== 1'b0)  begin errors++; $display("[TB] FAIL rst_tready: got %b, required 0", in_a.tready); end
      if (out_c.tvalid !== 1'b0) begin errors++; $display("[TB] FAIL rst_c_tvalid: got %b, required 0", out_c.tvalid); end
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (in_a.tready !== 1'b1) begin errors++; $display("[TB] FAIL rst_release_tready: got %b, required 1", in_a.tready); end
   endtask

   task automatic test_basic();
      int acc;
      int base_l;
      base_l = lasts_a;
      out_a.tready = 1'b1;
      send(0, 32'h1A2F, 1'b0, acc);
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         checks += 2;
         if (out_a.tvalid !== 1'b1) begin errors++; $display("[TB] FAIL basic_valid: cycle N+%0d got %b, required 1", k, out_a.tvalid); end
         if (in_a.tready !== 1'b0)  begin errors++; $display("[TB] FAIL basic_busy: cycle N+%0d tready %b, required 0", k, in_a.tready); end
      end
      @(negedge clk);
      checks += 2;
      if (in_a.tready !== 1'b1)  begin errors++; $display("[TB] FAIL basic_idle: cycle N+6 tready %b, required 1", in_a.tready); end
      if (out_a.tvalid !== 1'b0) begin errors++; $display("[TB] FAIL basic_done: cycle N+6 tvalid %b, required 0", out_a.tvalid); end
      wait_drain(0);
      checks++;
      if (lasts_a !== base_l) begin errors++; $display("[TB] FAIL basic_tlast: got %0d tlast beats, required %0d", lasts_a, base_l); end
   endtask

   task automatic test_last_word();
      int acc;
      int base_b, base_l;
      base_b = beats_a;
      base_l = lasts_a;
      send(0, 32'h00E5, 1'b1, acc);
      wait_drain(0);
      checks += 2;
      if (beats_a - base_b !== 6) begin errors++; $display("[TB] FAIL last_beats: got %0d, required 6", beats_a - base_b); end
      if (lasts_a - base_l !== 1) begin errors++; $display("[TB] FAIL last_count: got %0d, required 1", lasts_a - base_l); end
   endtask

   task automatic test_frame_stalled();
      int acc;
      int base_b, base_l;
      base_b = beats_a;
      base_l = lasts_a;
      out_a.tready = 1'b0;
      send(0, 32'h0010, 1'b0, acc);
      fork
         begin
            send(0, 32'hFFF0, 1'b0, acc);
            send(0, 32'h0100, 1'b1, acc);
         end
         begin
            repeat (20) begin
               @(negedge clk);
               checks += 2;
               if (in_a.tready !== 1'b0)  begin errors++; $display("[TB] FAIL frame_hold_in: got %b, required 0", in_a.tready); end
               if (out_a.tvalid !== 1'b1) begin errors++; $display("[TB] FAIL frame_hold_out: got %b, required 1", out_a.tvalid); end
            end
            @(posedge clk); #1;
            out_a.tready = 1'b1;
         end
      join
      wait_drain(0);
      checks += 2;
      if (beats_a - base_b !== 16) begin errors++; $display("[TB] FAIL frame_beats: got %0d, required 16", beats_a - base_b); end
      if (lasts_a - base_l !== 1)  begin errors++; $display("[TB] FAIL frame_tlast: got %0d, required 1", lasts_a - base_l); end
   endtask

   task automatic test_lowercase_random();
      int acc;
      bit sent;
      sent = 1'b0;
      fork
         begin
            send(1, 32'hBEEF, 1'b0, acc);
            sent = 1'b1;
         end
         begin
            for (int i = 0; i < 300 && !(sent && exp_b.size() == 0); i++) begin
               @(posedge clk); #1;
               out_b.tready = 1'($urandom_range(0, 1));
            end
         end
      join
      out_b.tready = 1'b1;
      wait_drain(1);
      checks++;
      if (beats_b !== 5) begin errors++; $display("[TB] FAIL lower_beats: got %0d, required 5", beats_b); end
   endtask

   task automatic test_reset_mid_word();
      int acc;
      int base_b, base_l;
      bit done;
      done   = 1'b0;
      base_b = beats_a;
      out_a.tready = 1'b1;
      send(0, 32'h1234, 1'b0, acc);
      for (int i = 0; i < 50 && !done; i++) begin
         @(posedge clk);
         if (beats_a - base_b >= 2) done = 1'b1;
      end
      #2;
      reset = 1'b0;
      #1;
      checks += 3;
      if (out_a.tvalid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_tvalid: got %b, required 0", out_a.tvalid); end
      if (out_a.tdata !== 8'h00) begin errors++; $display("[TB] FAIL midrst_tdata: got %h, required 00", out_a.tdata); end
      if (in_a.tready !== 1'b0)  begin errors++; $display("[TB] FAIL midrst_tready: got %b, required 0", in_a.tready); end
      exp_a.delete();
      repeat (3) @(negedge clk);
      reset = 1'b1;
      base_b = beats_a;
      base_l = lasts_a;
      send(0, 32'h5678, 1'b1, acc);
      wait_drain(0);
      checks += 2;
      if (beats_a - base_b !== 6) begin errors++; $display("[TB] FAIL midrst_beats: got %0d, required 6", beats_a - base_b); end
      if (lasts_a - base_l !== 1) begin errors++; $display("[TB] FAIL midrst_tlast: got %0d, required 1", lasts_a - base_l); end
   endtask

   task automatic test_width8();
      int acc;
      send(2, 32'h7F, 1'b0, acc);
      wait_drain(2);
      checks += 2;
      if (beats_c !== 3) begin errors++; $display("[TB] FAIL w8_beats: got %0d, required 3", beats_c); end
      if (lasts_c !== 0) begin errors++; $display("[TB] FAIL w8_tlast: got %0d, required 0", lasts_c); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      cyc    = 0;
      beats_a = 0; beats_b = 0; beats_c = 0;
      lasts_a = 0; lasts_b = 0; lasts_c = 0;
      hold_a = 1'b0; hold_b = 1'b0; hold_c = 1'b0;
      in_a.tvalid = 1'b0; in_a.tdata = '0; in_a.tlast = 1'b0;
      in_a.tkeep = '1; in_a.tuser = 1'b0; in_a.tid = '0; in_a.tdest = '0;
      in_b.tvalid = 1'b0; in_b.tdata = '0; in_b.tlast = 1'b0;
      in_b.tkeep = '1; in_b.tuser = 1'b0; in_b.tid = '0; in_b.tdest = '0;
      in_c.tvalid = 1'b0; in_c.tdata = '0; in_c.tlast = 1'b0;
      in_c.tkeep = '1; in_c.tuser = 1'b0; in_c.tid = '0; in_c.tdest = '0;
      out_a.tready = 1'b1;
      out_b.tready = 1'b1;
      out_c.tready = 1'b1;

      test_reset();
      test_basic();
      test_last_word();
      test_frame_stalled();
      test_lowercase_random();
      test_width8();
      test_reset_mid_word();

      repeat (3) @(negedge clk);
      checks += 3;
      if (exp_a.size() != 0) begin errors++; $display("[TB] FAIL leftover_a: got %0d bytes owed, required 0", exp_a.size()); end
      if (exp_b.size() != 0) begin errors++; $display("[TB] FAIL leftover_b: got %0d bytes owed, required 0", exp_b.size()); end
      if (exp_c.size() != 0) begin errors++; $display("[TB] FAIL leftover_c: got %0d bytes owed, required 0", exp_c.size()); end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
